// File: rtl/stage_memory.sv
// EX->MEM pipeline stage: issues data-memory requests, aligns store lanes,
// extends load data and registers everything writeback consumes.
module stage_memory #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_rd_en,
  input  logic              ex_mem_wr_en,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic [1:0]        ex_result_src,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_write_data,
  input  logic [31:0]       ex_instr_addr_plus,
  input  logic              ex_regfile_wr_enable,
  output logic              mem_stall,
  output logic [4:0]        mem_rd,
  output logic [1:0]        mem_result_src,
  output logic [31:0]       mem_alu_result,
  output logic [31:0]       mem_read_data,
  output logic [31:0]       mem_instr_addr_plus,
  output logic              mem_regfile_wr_enable,
  output logic              mem_fault,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  // state | meaning
  // IDLE  | no access outstanding; EX ops retire in one cycle
  // REQ   | request on the bus, waiting for dmem_ready
  // RSP   | load accepted, waiting for dmem_rvalid
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  logic [1:0]  state;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [4:0]  op_rd;
  logic [1:0]  op_result_src;
  logic [31:0] op_alu_result;
  logic [31:0] op_write_data;
  logic [31:0] op_instr_addr_plus;
  logic        op_regfile_wr_enable;
  logic [3:0]  op_be;

  logic [1:0]  ex_off;
  logic        ex_is_mem;
  logic        ex_fault;
  logic [3:0]  ex_be;
  logic [31:0] ex_wdata;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;

  always_comb begin
    ex_off    = ex_alu_result[1:0];
    ex_is_mem = ex_valid & (ex_mem_rd_en | ex_mem_wr_en);
    ex_fault  = 1'b0;
    ex_be     = 4'b1111;
    ex_wdata  = ex_write_data;
    case (ex_funct3[1:0])
      2'b00: begin
        ex_be    = 4'b0001 << ex_off;
        ex_wdata = {4{ex_write_data[7:0]}};
      end
      2'b01: begin
        ex_be    = 4'b0011 << ex_off;
        ex_wdata = {2{ex_write_data[15:0]}};
        ex_fault = ex_off[0];
      end
      2'b10:   ex_fault = |ex_off;
      default: ex_fault = 1'b1;
    endcase
    // Loads allow the unsigned byte/half codes; stores have no funct3[2] variants.
    if (ex_mem_rd_en) begin
      if (ex_funct3 == 3'b110) ex_fault = 1'b1;
    end else begin
      if (ex_funct3[2]) ex_fault = 1'b1;
    end
    ex_fault = ex_fault & ex_is_mem;
  end

  always_comb begin
    rd_shifted = dmem_rdata >> {op_alu_result[1:0], 3'b000};
    case (op_funct3)
      3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_data = {24'd0, rd_shifted[7:0]};
      3'b101:  load_data = {16'd0, rd_shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  assign mem_stall  = (state != S_IDLE);
  assign dmem_req   = (state == S_REQ);
  assign dmem_we    = dmem_req & op_store;
  assign dmem_be    = dmem_req ? op_be : 4'b0000;
  assign dmem_addr  = {op_alu_result[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = op_write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= S_IDLE;
      mem_rd                <= '0;
      mem_result_src        <= '0;
      mem_alu_result        <= '0;
      mem_read_data         <= '0;
      mem_instr_addr_plus   <= '0;
      mem_regfile_wr_enable <= 1'b0;
      mem_fault             <= 1'b0;
      op_store              <= 1'b0;
      op_funct3             <= '0;
      op_rd                 <= '0;
      op_result_src         <= '0;
      op_alu_result         <= '0;
      op_write_data         <= '0;
      op_instr_addr_plus    <= '0;
      op_regfile_wr_enable  <= 1'b0;
      op_be                 <= '0;
    end else begin
      mem_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_is_mem && !ex_fault) begin
            op_store              <= ~ex_mem_rd_en;
            op_funct3             <= ex_funct3;
            op_rd                 <= ex_rd;
            op_result_src         <= ex_result_src;
            op_alu_result         <= ex_alu_result;
            op_write_data         <= ex_wdata;
            op_instr_addr_plus    <= ex_instr_addr_plus;
            op_regfile_wr_enable  <= ex_regfile_wr_enable;
            op_be                 <= ex_be;
            mem_regfile_wr_enable <= 1'b0;
            state                 <= S_REQ;
          end else begin
            mem_rd                <= ex_rd;
            mem_result_src        <= ex_result_src;
            mem_alu_result        <= ex_alu_result;
            mem_instr_addr_plus   <= ex_instr_addr_plus;
            mem_regfile_wr_enable <= ex_valid & ex_regfile_wr_enable & ~ex_fault;
            mem_fault             <= ex_fault;
          end
        end
        S_REQ: begin
          mem_regfile_wr_enable <= 1'b0;
          if (dmem_ready) begin
            if (op_store) begin
              mem_rd              <= op_rd;
              mem_result_src      <= op_result_src;
              mem_alu_result      <= op_alu_result;
              mem_instr_addr_plus <= op_instr_addr_plus;
              state               <= S_IDLE;
            end else begin
              state <= S_RSP;
            end
          end
        end
        S_RSP: begin
          mem_regfile_wr_enable <= 1'b0;
          if (dmem_rvalid) begin
            mem_rd                <= op_rd;
            mem_result_src        <= op_result_src;
            mem_alu_result        <= op_alu_result;
            mem_read_data         <= load_data;
            mem_instr_addr_plus   <= op_instr_addr_plus;
            mem_regfile_wr_enable <= op_regfile_wr_enable;
            state                 <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed cases with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_rd_en, ex_mem_wr_en;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_result_src;
  logic [31:0] ex_alu_result, ex_write_data, ex_instr_addr_plus;
  logic        ex_regfile_wr_enable;
  logic        mem_stall;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_read_data, mem_instr_addr_plus;
  logic        mem_regfile_wr_enable, mem_fault;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;

  stage_memory #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_rd_en(ex_mem_rd_en), .ex_mem_wr_en(ex_mem_wr_en),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_result_src(ex_result_src),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_instr_addr_plus(ex_instr_addr_plus), .ex_regfile_wr_enable(ex_regfile_wr_enable),
    .mem_stall(mem_stall), .mem_rd(mem_rd), .mem_result_src(mem_result_src),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_instr_addr_plus(mem_instr_addr_plus), .mem_regfile_wr_enable(mem_regfile_wr_enable),
    .mem_fault(mem_fault), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: expected registered outputs plus the one outstanding access, if any.
  logic [4:0]  e_rd;
  logic [1:0]  e_rsrc;
  logic [31:0] e_alu, e_rdata, e_pcp;
  logic        e_wen, e_fault;
  bit          pend, accepted;
  bit          o_store, o_wen;
  logic [2:0]  o_f3;
  logic [4:0]  o_rd;
  logic [1:0]  o_rsrc;
  logic [31:0] o_alu, o_wd, o_pcp;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned acc_size(logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit is_bad(bit store, logic [2:0] f3, logic [31:0] a);
    if (store && f3 >= 3'd3) return 1'b1;
    if (!store && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(logic [2:0] f3, logic [31:0] a);
    int unsigned m;
    m = ((32'd1 << acc_size(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] d);
    if (acc_size(f3) == 1) return (d & 32'hFF) * 32'h01010101;
    if (acc_size(f3) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_ext(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    logic [31:0] v;
    v = w >> ((a % 4) * 8);
    if (acc_size(f3) == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v - 32'd256;
    end else if (acc_size(f3) == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic model_reset();
    e_rd = '0; e_rsrc = '0; e_alu = '0; e_rdata = '0; e_pcp = '0;
    e_wen = 1'b0; e_fault = 1'b0; pend = 1'b0; accepted = 1'b0;
  endtask

  task automatic retire_op();
    e_rd = o_rd; e_rsrc = o_rsrc; e_alu = o_alu; e_pcp = o_pcp;
  endtask

  task automatic model_next();
    if (rst) begin
      model_reset();
      return;
    end
    e_fault = 1'b0;
    e_wen   = 1'b0;
    if (!pend) begin
      if (ex_valid && (ex_mem_rd_en || ex_mem_wr_en) &&
          !is_bad(!ex_mem_rd_en, ex_funct3, ex_alu_result)) begin
        pend = 1'b1; accepted = 1'b0;
        o_store = !ex_mem_rd_en; o_f3 = ex_funct3; o_rd = ex_rd; o_rsrc = ex_result_src;
        o_alu = ex_alu_result; o_wd = ex_write_data; o_pcp = ex_instr_addr_plus;
        o_wen = ex_regfile_wr_enable;
      end else begin
        e_rd = ex_rd; e_rsrc = ex_result_src; e_alu = ex_alu_result; e_pcp = ex_instr_addr_plus;
        e_fault = ex_valid && (ex_mem_rd_en || ex_mem_wr_en);
        e_wen = ex_valid && ex_regfile_wr_enable && !e_fault;
      end
    end else if (!accepted) begin
      if (dmem_ready) begin
        if (o_store) begin
          retire_op();
          pend = 1'b0;
        end else begin
          accepted = 1'b1;
        end
      end
    end else if (dmem_rvalid) begin
      retire_op();
      e_rdata = exp_ext(o_f3, o_alu, dmem_rdata);
      e_wen = o_wen;
      pend = 1'b0;
    end
  endtask

  task automatic check_comb();
    chk("stall", {31'd0, mem_stall}, {31'd0, pend});
    chk("dmem_req", {31'd0, dmem_req}, {31'd0, pend && !accepted});
    if (pend && !accepted) begin
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, o_store});
      chk("dmem_addr", dmem_addr, o_alu & ~32'd3);
      if (o_store) begin
        chk("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be(o_f3, o_alu)});
        chk("dmem_wdata", dmem_wdata, exp_wdata(o_f3, o_wd));
      end
    end
  endtask

  task automatic check_regs();
    chk("mem_rd", {27'd0, mem_rd}, {27'd0, e_rd});
    chk("mem_result_src", {30'd0, mem_result_src}, {30'd0, e_rsrc});
    chk("mem_alu_result", mem_alu_result, e_alu);
    chk("mem_read_data", mem_read_data, e_rdata);
    chk("mem_instr_addr_plus", mem_instr_addr_plus, e_pcp);
    chk("mem_wr_enable", {31'd0, mem_regfile_wr_enable}, {31'd0, e_wen});
    chk("mem_fault", {31'd0, mem_fault}, {31'd0, e_fault});
  endtask

  task automatic step();
    check_comb();
    model_next();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic set_ex(bit v, bit rde, bit wre, logic [2:0] f3, logic [4:0] rd,
                        logic [31:0] alu, logic [31:0] wd, bit wen);
    ex_valid = v; ex_mem_rd_en = rde; ex_mem_wr_en = wre; ex_funct3 = f3; ex_rd = rd;
    ex_result_src = 2'd1; ex_alu_result = alu; ex_write_data = wd;
    ex_instr_addr_plus = alu + 32'd4; ex_regfile_wr_enable = wen;
  endtask

  task automatic set_bubble();
    set_ex(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int stall_cnt, wen_cnt, kind;
    bit memop, isload;
    logic [2:0] f3;
    rst = 1'b1; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    set_bubble();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_wen", {31'd0, mem_regfile_wr_enable}, 32'd0);
    chk("rst_alu", mem_alu_result, 32'd0);
    rst = 1'b0;

    set_ex(1, 0, 0, 3'd0, 5'd5, 32'h1234, 32'd0, 1);
    step();
    chk("add_alu", mem_alu_result, 32'h1234);
    chk("add_wen", {31'd0, mem_regfile_wr_enable}, 32'd1);
    chk("add_stall", {31'd0, mem_stall}, 32'd0);

    set_ex(1, 0, 1, 3'b000, 5'd3, 32'h103, 32'h0000_00AB, 0);
    dmem_ready = 1'b1;
    step();
    set_bubble();
    chk("sb_stall", {31'd0, mem_stall}, 32'd1);
    chk("sb_req", {31'd0, dmem_req}, 32'd1);
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_be", {28'd0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_addr", dmem_addr, 32'h100);
    step();
    chk("sb_done_stall", {31'd0, mem_stall}, 32'd0);
    chk("sb_wen", {31'd0, mem_regfile_wr_enable}, 32'd0);

    for (int k = 0; k < 2; k++) begin
      set_ex(1, 1, 0, (k == 0) ? 3'b000 : 3'b100, 5'd7, 32'h102, 32'd0, 1);
      dmem_ready = 1'b1;
      step();
      set_bubble();
      step();
      dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000;
      step();
      dmem_rvalid = 1'b0;
      chk(k == 0 ? "lb_data" : "lbu_data", mem_read_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      chk("lb_wen", {31'd0, mem_regfile_wr_enable}, 32'd1);
      chk("lb_rd", {27'd0, mem_rd}, 32'd7);
    end

    set_ex(1, 1, 0, 3'b010, 5'd9, 32'h100, 32'd0, 1);
    dmem_ready = 1'b0;
    step();
    stall_cnt = mem_stall; wen_cnt = mem_regfile_wr_enable;
    set_bubble();
    repeat (3) begin
      step();
      stall_cnt += mem_stall; wen_cnt += mem_regfile_wr_enable;
    end
    dmem_ready = 1'b1;
    step();
    stall_cnt += mem_stall; wen_cnt += mem_regfile_wr_enable;
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    stall_cnt += mem_stall; wen_cnt += mem_regfile_wr_enable;
    dmem_rvalid = 1'b0;
    chk("lw_stall_cycles", stall_cnt, 32'd5);
    chk("lw_write_count", wen_cnt, 32'd1);
    chk("lw_data", mem_read_data, 32'hCAFE_F00D);

    set_ex(1, 0, 1, 3'b010, 5'd4, 32'h102, 32'hDEAD, 0);
    step();
    chk("sw_fault", {31'd0, mem_fault}, 32'd1);
    chk("sw_req", {31'd0, dmem_req}, 32'd0);
    chk("sw_stall", {31'd0, mem_stall}, 32'd0);
    chk("sw_wen", {31'd0, mem_regfile_wr_enable}, 32'd0);
    set_bubble();
    step();
    chk("sw_fault_pulse", {31'd0, mem_fault}, 32'd0);

    set_ex(1, 1, 0, 3'b010, 5'd6, 32'h100, 32'd0, 1);
    dmem_ready = 1'b1;
    step();
    set_bubble();
    step();
    chk("rsp_stall", {31'd0, mem_stall}, 32'd1);
    rst = 1'b1; dmem_ready = 1'b0;
    step();
    chk("rstrsp_stall", {31'd0, mem_stall}, 32'd0);
    chk("rstrsp_alu", mem_alu_result, 32'd0);
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    chk("late_rsp_data", mem_read_data, 32'd0);
    chk("late_rsp_wen", {31'd0, mem_regfile_wr_enable}, 32'd0);
    chk("late_rsp_stall", {31'd0, mem_stall}, 32'd0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!pend) begin
        kind = $urandom_range(0, 9);
        memop = (kind >= 5);
        isload = (kind <= 7);
        f3 = $urandom_range(0, 7);
        if (memop && $urandom_range(0, 3) != 0)
          f3 = isload ? 3'($urandom_range(0, 2) + (($urandom_range(0, 1) == 1) ? 0 : 0)) : 3'($urandom_range(0, 2));
        if (memop && isload && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
        set_ex(kind != 0, memop && isload, memop && !isload, f3, 5'($urandom),
               memop ? (32'h0000_0100 | 32'($urandom_range(0, 15))) : $urandom,
               $urandom, $urandom_range(0, 1) == 1);
        ex_result_src = 2'($urandom);
        ex_instr_addr_plus = $urandom;
        if (kind == 0) begin
          ex_mem_rd_en = $urandom_range(0, 1) == 1;
          ex_mem_wr_en = 1'b0;
        end
      end
      dmem_ready = $urandom_range(0, 1) == 1;
      dmem_rvalid = (pend && !accepted && dmem_ready) ? 1'b0 : ($urandom_range(0, 1) == 1);
      dmem_rdata = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
